// File: rtl/kernel_seidel_2d_udiv_seq.sv
// kernel_seidel_2d_udiv_seq
//   Sequential unsigned restoring divider for the seidel-2d datapath. Splits a
//   flattened index back into quotient (row) and remainder (col), one quotient
//   bit per enabled clock, MSB first, with valid/ready handshakes on both sides.
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   ce        clock enable; all state frozen when low
//   in_vld    operand pair valid          in_rdy    block can accept operands
//   dividend  unsigned dividend           divisor   unsigned divisor
//   out_vld   result valid                out_rdy   consumer accepts result
//   quotient  unsigned quotient           remainder unsigned remainder
//   div_zero  result came from a zero divisor
module kernel_seidel_2d_udiv_seq #(
   parameter int unsigned DIVIDEND_W = 20,
   parameter int unsigned DIVISOR_W  = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_zero
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                r_state;
   // Holds the dividend on entry; quotient bits shift in from the bottom as
   // dividend bits shift out of the top.
   logic [DIVIDEND_W-1:0] r_work;
   logic [DIVISOR_W-1:0]  r_divisor;
   logic [DIVISOR_W:0]    r_prem;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_in_rdy;
   logic                  r_out_vld;
   logic [DIVIDEND_W-1:0] r_quotient;
   logic [DIVISOR_W-1:0]  r_remainder;
   logic                  r_div_zero;

   logic [DIVISOR_W:0]    w_shift;
   logic                  w_ge;
   logic [DIVISOR_W:0]    w_prem_nxt;
   logic [DIVIDEND_W-1:0] w_work_nxt;

   // Partial remainder stays below the divisor, so its top bit is only ever
   // set for a zero divisor, where dropping it leaves dividend's low bits.
   assign w_shift    = {r_prem[DIVISOR_W-1:0], r_work[DIVIDEND_W-1]};
   assign w_ge       = (w_shift >= {1'b0, r_divisor});
   assign w_prem_nxt = w_ge ? (w_shift - {1'b0, r_divisor}) : w_shift;
   assign w_work_nxt = {r_work[DIVIDEND_W-2:0], w_ge};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_work      <= '0;
         r_divisor   <= '0;
         r_prem      <= '0;
         r_cnt       <= '0;
         r_in_rdy    <= 1'b1;
         r_out_vld   <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_div_zero  <= 1'b0;
      end else if (ce) begin
         case (r_state)
            IDLE: begin
               if (in_vld) begin
                  r_work    <= dividend;
                  r_divisor <= divisor;
                  r_prem    <= '0;
                  r_cnt     <= '0;
                  r_in_rdy  <= 1'b0;
                  r_state   <= CALC;
               end
            end
            CALC: begin
               r_work <= w_work_nxt;
               r_prem <= w_prem_nxt;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == LAST_STEP) begin
                  r_state     <= DONE;
                  r_out_vld   <= 1'b1;
                  r_quotient  <= w_work_nxt;
                  r_remainder <= w_prem_nxt[DIVISOR_W-1:0];
                  r_div_zero  <= (r_divisor == '0);
               end
            end
            DONE: begin
               if (out_rdy) begin
                  r_state   <= IDLE;
                  r_out_vld <= 1'b0;
                  r_in_rdy  <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_out_vld <= 1'b0;
               r_in_rdy  <= 1'b1;
            end
         endcase
      end
   end

   assign in_rdy    = r_in_rdy;
   assign out_vld   = r_out_vld;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_kernel_seidel_2d_udiv_seq.sv
// tb_kernel_seidel_2d_udiv_seq
//   Directed cases with literal expectations, then randomized traffic, all
//   checked every cycle against a transaction-level model of the divider.
module tb_kernel_seidel_2d_udiv_seq;

   localparam int unsigned DW = 20;
   localparam int unsigned SW = 11;
   localparam int LAT = DW + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          ce;
   logic          in_vld;
   logic          in_rdy;
   logic [DW-1:0] dividend;
   logic [SW-1:0] divisor;
   logic          out_vld;
   logic          out_rdy;
   logic [DW-1:0] quotient;
   logic [SW-1:0] remainder;
   logic          div_zero;

   int checks = 0;
   int errors = 0;

   kernel_seidel_2d_udiv_seq #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .ce        (ce),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Transaction model: busy from the accept edge until the result is taken;
   // the result appears after LAT enabled edges counting the accept edge.
   bit            m_busy;
   int            m_edges;
   logic [DW-1:0] m_a;
   logic [SW-1:0] m_b;
   logic [DW-1:0] m_q;
   logic [SW-1:0] m_r;
   bit            m_z;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 0; m_edges = 0; m_q = '0; m_r = '0; m_z = 0;
      end else if (ce) begin
         if (!m_busy) begin
            if (in_vld) begin
               m_busy = 1; m_edges = 1; m_a = dividend; m_b = divisor;
            end
         end else if (m_edges < LAT) begin
            m_edges++;
            if (m_edges == LAT) begin
               if (m_b == 0) begin
                  m_q = '1; m_r = m_a[SW-1:0]; m_z = 1;
               end else begin
                  m_q = m_a / DW'(m_b); m_r = SW'(m_a % DW'(m_b)); m_z = 0;
               end
            end
         end else if (out_rdy) begin
            m_busy = 0;
         end
      end
   end

   // Compare every cycle, well clear of both clock edges.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         chk("cmp_in_rdy", 32'(in_rdy), 32'(!m_busy));
         chk("cmp_out_vld", 32'(out_vld), 32'(m_busy && m_edges == LAT));
         chk("cmp_quotient", 32'(quotient), 32'(m_q));
         chk("cmp_remainder", 32'(remainder), 32'(m_r));
         chk("cmp_div_zero", 32'(div_zero), 32'(m_z));
      end
   end

   // Issue one op and wait for out_vld; ce dropped for stall_len edges after
   // edge number stall_at. Returns the number of clock edges taken.
   task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] b,
                         input int stall_at, input int stall_len, output int edges);
      edges = 0;
      dividend = a; divisor = b; in_vld = 1'b1; ce = 1'b1; out_rdy = 1'b0;
      while (1) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         in_vld = 1'b0;
         ce = !(edges >= stall_at && edges < stall_at + stall_len);
         if (out_vld) break;
         if (edges > 200) begin
            chk("run_op_timeout", 32'(out_vld), 32'd1);
            break;
         end
      end
      ce = 1'b1;
   endtask

   task automatic consume();
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_rdy = 1'b0;
      chk("consume_in_rdy", 32'(in_rdy), 32'd1);
      chk("consume_out_vld", 32'(out_vld), 32'd0);
   endtask

   initial begin
      int e;
      logic [DW-1:0] hold_q;
      logic [SW-1:0] hold_r;
      reset = 1'b0; ce = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
      dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_rdy", 32'(in_rdy), 32'd1);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_div_zero", 32'(div_zero), 32'd0);
      reset = 1'b1; ce = 1'b1;
      @(negedge clk);

      // 100000 / 7
      run_op(20'd100000, 11'd7, 0, 0, e);
      chk("t1_latency", 32'(e), 32'd21);
      chk("t1_q", 32'(quotient), 32'd14285);
      chk("t1_r", 32'(remainder), 32'd5);
      chk("t1_z", 32'(div_zero), 32'd0);
      consume();

      // max dividend / max divisor
      run_op(20'hFFFFF, 11'd2047, 0, 0, e);
      chk("t2_q", 32'(quotient), 32'd512);
      chk("t2_r", 32'(remainder), 32'd511);
      consume();

      // dividend < divisor, then divide by zero
      run_op(20'd5, 11'd9, 0, 0, e);
      chk("t3a_q", 32'(quotient), 32'd0);
      chk("t3a_r", 32'(remainder), 32'd5);
      consume();
      run_op(20'd12345, 11'd0, 0, 0, e);
      chk("t3b_latency", 32'(e), 32'd21);
      chk("t3b_q", 32'(quotient), 32'hFFFFF);
      chk("t3b_r", 32'(remainder), 32'd57);
      chk("t3b_z", 32'(div_zero), 32'd1);
      consume();

      // Backpressure with a competing request held on the input
      run_op(20'd1000, 11'd30, 0, 0, e);
      hold_q = quotient; hold_r = remainder;
      dividend = 20'd77; divisor = 11'd3; in_vld = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         chk("t4_out_vld", 32'(out_vld), 32'd1);
         chk("t4_in_rdy", 32'(in_rdy), 32'd0);
         chk("t4_q_stable", 32'(quotient), 32'(hold_q));
         chk("t4_r_stable", 32'(remainder), 32'(hold_r));
      end
      chk("t4_q", 32'(quotient), 32'd33);
      chk("t4_r", 32'(remainder), 32'd10);
      in_vld = 1'b0;
      consume();

      // ce low for 10 cycles mid-CALC
      run_op(20'd100000, 11'd7, 5, 10, e);
      chk("t5_latency", 32'(e), 32'd31);
      chk("t5_q", 32'(quotient), 32'd14285);
      chk("t5_r", 32'(remainder), 32'd5);
      consume();

      // Reset at CALC step 8 aborts the op and clears the result
      dividend = 20'd999999; divisor = 11'd13; in_vld = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_out_vld", 32'(out_vld), 32'd0);
      chk("t6_in_rdy", 32'(in_rdy), 32'd1);
      chk("t6_q", 32'(quotient), 32'd0);
      chk("t6_r", 32'(remainder), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_op(20'd64, 11'd8, 0, 0, e);
      chk("t6_next_q", 32'(quotient), 32'd8);
      chk("t6_next_r", 32'(remainder), 32'd0);
      consume();

      // Randomized traffic; the compare process does the checking.
      for (int i = 0; i < 4000; i++) begin
         int sel;
         @(negedge clk);
         ce      = ($urandom_range(0, 9) != 0);
         in_vld  = ($urandom_range(0, 3) != 0);
         out_rdy = ($urandom_range(0, 2) != 0);
         sel = $urandom_range(0, 9);
         divisor = (sel == 0) ? 11'd0 : (sel == 1) ? 11'd2047 : (sel == 2) ? 11'd1 :
                   SW'($urandom);
         sel = $urandom_range(0, 9);
         dividend = (sel == 0) ? 20'hFFFFF : (sel == 1) ? DW'($urandom_range(0, 2047)) :
                    DW'($urandom);
         reset = ($urandom_range(0, 299) != 0);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
